platform_rider: RTL and testbench

Player-side counterpart to the platform block. Each frame it detects which player is standing on which floor button and drives the `buttonTrigger` matrix that moves the platforms. It also tracks whether each player is standing on a moving platform and reports a signed per-frame vertical carry offset, so the player-motion logic can keep riders attached. It sits between the two player-motion blocks and the platform block, clocked once per video frame.

---
 rtl/platform_pkg.sv | 25 ++
 rtl/platform_rider_fsm.sv | 68 ++++++
 rtl/platform_rider.sv | 103 ++++++++++
 tb/tb_platform_rider.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// Shared constants and rider-state encoding for the platform and platform_rider blocks.
// Includes the x-overlap helper used by both contact and rider detection.
package platform_pkg;

  localparam int PF_W       = 48;
  localparam int PF_H       = 16;
  localparam int BTN_W      = 16;
  localparam int BTN_H      = 4;
  localparam int TILE_SHIFT = 4;

  typedef enum logic [1:0] {FREE, LANDING, RIDING} rider_state_t;

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_LANDING = 2'd1;
  localparam logic [1:0] ST_RIDING  = 2'd2;

  // Widened operands so that ox+w and px+pw never wrap.
  function automatic logic x_overlap(input logic [9:0] px, input logic [14:0] ox,
                                     input logic [14:0] w, input logic [14:0] pw);
    logic [14:0] pxw;
    pxw = {5'd0, px};
    return (pxw < ox + w) && (pxw + pw > ox);
  endfunction

endpackage

// File: rtl/platform_rider_fsm.sv
// Per-player rider tracker: FREE/LANDING/RIDING state, latched platform index
// and the registered vertical carry offset.
module rider_fsm
  import platform_pkg::*;
(
  input  logic              frame_clk,
  input  logic              RESET,
  input  logic [9:0]        feet_y,
  input  logic [1:0]        pf_xov,
  input  logic [9:0]        pf_y [2],
  input  logic signed [1:0] pf_dy [2],
  output logic              riding,
  output logic              ride_pf,
  output logic signed [1:0] carry_dy
);

  logic [1:0]        state, state_nx;
  logic              sel_nx;
  logic              land0, land1, on_sel, jump_away, too_far;
  logic signed [10:0] diff;
  logic signed [1:0] carry_nx;

  always_comb begin
    state_nx  = state;
    sel_nx    = ride_pf;
    land0     = pf_xov[0] && (feet_y == pf_y[0]);
    land1     = pf_xov[1] && (feet_y == pf_y[1]);
    on_sel    = pf_xov[ride_pf] && (feet_y == pf_y[ride_pf]);
    diff      = $signed({1'b0, feet_y}) - $signed({1'b0, pf_y[ride_pf]});
    too_far   = (diff > 11'sd1) || (diff < -11'sd1);
    jump_away = ({1'b0, feet_y} + 11'd1) < {1'b0, pf_y[ride_pf]};

    case (state)
      ST_FREE: begin
        if (land0) begin
          state_nx = ST_LANDING;
          sel_nx   = 1'b0;
        end else if (land1) begin
          state_nx = ST_LANDING;
          sel_nx   = 1'b1;
        end
      end
      ST_LANDING: state_nx = on_sel ? ST_RIDING : ST_FREE;
      ST_RIDING:  if (!pf_xov[ride_pf] || too_far) state_nx = ST_FREE;
      default:    state_nx = ST_FREE;
    endcase

    // A jump clears attachment regardless of how far the FSM got.
    if (state != ST_FREE && jump_away) state_nx = ST_FREE;

    carry_nx = (state_nx == ST_RIDING) ? pf_dy[sel_nx] : 2'sd0;
  end

  always_ff @(posedge frame_clk or posedge RESET) begin
    if (RESET) begin
      state    <= ST_FREE;
      ride_pf  <= 1'b0;
      carry_dy <= 2'sd0;
    end else begin
      state    <= state_nx;
      ride_pf  <= sel_nx;
      carry_dy <= carry_nx;
    end
  end

  assign riding = (state == ST_RIDING);

endmodule

// File: rtl/platform_rider.sv
// Button-press detection and platform-rider tracking for two players, once per frame.
// PLATFORM_RIDER_HOLD_EN enables the per-button hold counters (HOLD frames of trailing trigger).
module platform_rider
  import platform_pkg::*;
#(
  parameter int PW   = 16,
  parameter int PH   = 32,
  parameter int HOLD = 8
) (
  input  logic              frame_clk,
  input  logic              RESET,
  input  logic [9:0]        playerX [2],
  input  logic [9:0]        playerY [2],
  input  logic [9:0]        pfX [2],
  input  logic [9:0]        pfY [2],
  input  logic [9:0]        buttonX [4],
  input  logic [9:0]        buttonY [4],
  output logic [3:0]        buttonTrigger [2],
  output logic              riding [2],
  output logic              ridePf [2],
  output logic signed [1:0] carryDY [2]
);

  logic [9:0]        feet [2];
  logic [3:0]        contact [2];
  logic [1:0]        pf_xov [2];
  logic [9:0]        pfYq [2];
  logic signed [1:0] pf_dy [2];

  always_comb begin
    logic [14:0] bx, by, fw;
    bx = '0;
    by = '0;
    fw = '0;
    for (int p = 0; p < 2; p++) begin
      feet[p] = playerY[p] + 10'(PH);
      fw      = {5'd0, feet[p]};
      for (int b = 0; b < 4; b++) begin
        bx = {5'd0, buttonX[b]} << TILE_SHIFT;
        by = {5'd0, buttonY[b]} << TILE_SHIFT;
        contact[p][b] = x_overlap(playerX[p], bx, 15'(BTN_W), 15'(PW)) &&
                        (fw >= by) && (fw < by + 15'(BTN_H));
      end
      for (int k = 0; k < 2; k++)
        pf_xov[p][k] = x_overlap(playerX[p], {5'd0, pfX[k]}, 15'(PF_W), 15'(PW));
    end
    for (int k = 0; k < 2; k++)
      pf_dy[k] = 2'(pfY[k] - pfYq[k]);
  end

  // Loaded every frame, reset included, so the first post-reset delta is zero.
  always_ff @(posedge frame_clk) begin
    pfYq <= pfY;
  end

`ifdef PLATFORM_RIDER_HOLD_EN
  localparam logic [3:0] HOLD_LD = 4'(HOLD);

  logic [3:0] hold_cnt [2][4];

  always_ff @(posedge frame_clk or posedge RESET) begin
    if (RESET) begin
      for (int p = 0; p < 2; p++) begin
        buttonTrigger[p] <= '0;
        for (int b = 0; b < 4; b++) hold_cnt[p][b] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < 4; b++) begin
          buttonTrigger[p][b] <= contact[p][b] || (hold_cnt[p][b] != 4'd0);
          if (contact[p][b])
            hold_cnt[p][b] <= HOLD_LD;
          else if (hold_cnt[p][b] != 4'd0)
            hold_cnt[p][b] <= hold_cnt[p][b] - 4'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge frame_clk or posedge RESET) begin
    if (RESET) begin
      for (int p = 0; p < 2; p++) buttonTrigger[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) buttonTrigger[p] <= contact[p];
    end
  end
`endif

  for (genvar p = 0; p < 2; p++) begin : g_rider
    rider_fsm u_rider_fsm (
      .frame_clk (frame_clk),
      .RESET     (RESET),
      .feet_y    (feet[p]),
      .pf_xov    (pf_xov[p]),
      .pf_y      (pfY),
      .pf_dy     (pf_dy),
      .riding    (riding[p]),
      .ride_pf   (ridePf[p]),
      .carry_dy  (carryDY[p])
    );
  end

endmodule

// File: tb/tb_platform_rider.sv
// Scoreboard bench for platform_rider: expected output words are queued as each
// frame's stimulus is driven and compared after the frame edge.
module tb_platform_rider;

`ifdef PLATFORM_RIDER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic              frame_clk;
  logic              RESET;
  logic [9:0]        playerX [2];
  logic [9:0]        playerY [2];
  logic [9:0]        pfX [2];
  logic [9:0]        pfY [2];
  logic [9:0]        buttonX [4];
  logic [9:0]        buttonY [4];
  logic [3:0]        buttonTrigger [2];
  logic              riding [2];
  logic              ridePf [2];
  logic signed [1:0] carryDY [2];

  logic [15:0] sb [$];
  logic [15:0] got, exp_v;
  int checks = 0;
  int passed = 0;

  platform_rider #(.PW(16), .PH(32), .HOLD(8)) dut (
    .frame_clk     (frame_clk),
    .RESET         (RESET),
    .playerX       (playerX),
    .playerY       (playerY),
    .pfX           (pfX),
    .pfY           (pfY),
    .buttonX       (buttonX),
    .buttonY       (buttonY),
    .buttonTrigger (buttonTrigger),
    .riding        (riding),
    .ridePf        (ridePf),
    .carryDY       (carryDY)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Output word layout: {trig0, trig1, riding0, riding1, ridePf0, ridePf1, dy0, dy1}
  function automatic logic [15:0] mk(input logic [3:0] t0, input logic [3:0] t1,
                                     input logic r0, input logic r1,
                                     input logic p0, input logic p1,
                                     input logic [1:0] d0, input logic [1:0] d1);
    return {t0, t1, r0, r1, p0, p1, d0, d1};
  endfunction

  function automatic logic [15:0] observed();
    return {buttonTrigger[0], buttonTrigger[1], riding[0], riding[1],
            ridePf[0], ridePf[1], carryDY[0], carryDY[1]};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_idle();
    for (int p = 0; p < 2; p++) begin
      playerX[p] = 10'd0;
      playerY[p] = 10'd0;
      pfX[p]     = 10'd600;
      pfY[p]     = 10'd400;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    RESET = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== 16'h0000) $display("FAIL reset_async: got %h expected %h", got, 16'h0000);
    else passed++;
    tick();
    RESET = 1'b0;
    sb.push_back(mk(4'b0, 4'b0, 0, 0, 0, 0, 2'b00, 2'b00));
    tick();
    got = observed();
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v) $display("FAIL reset_idle: got %h expected %h", got, exp_v);
    else passed++;
  endtask

  task automatic test_button_hold();
    do_reset();
    playerX[0] = 10'd240;
    playerY[0] = 10'd304;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(4'b0001, 4'b0, 0, 0, 0, 0, 2'b00, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL button_on f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
    end
    set_idle();
    for (int i = 1; i <= 10; i++) begin
      sb.push_back(mk((HOLD_EN && i <= 8) ? 4'b0001 : 4'b0000, 4'b0, 0, 0, 0, 0, 2'b00, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL button_hold f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
    end
  endtask

  task automatic test_two_players();
    do_reset();
    playerX[1] = 10'd400;
    playerY[1] = 10'd304;
    playerX[0] = 10'd480;
    playerY[0] = 10'd304;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(4'b1000, 4'b0100, 0, 0, 0, 0, 2'b00, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL two_players f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
    end
    set_idle();
    for (int i = 1; i <= 9; i++) begin
      sb.push_back(mk((HOLD_EN && i <= 8) ? 4'b1000 : 4'b0000,
                      (HOLD_EN && i <= 8) ? 4'b0100 : 4'b0000, 0, 0, 0, 0, 2'b00, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL two_players_off f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    playerX[0] = 10'd320;  playerY[0] = 10'd304;
    playerX[1] = 10'd320;  playerY[1] = 10'd304;
    sb.push_back(mk(4'b0010, 4'b0010, 0, 0, 0, 0, 2'b00, 2'b00));
    tick();
    got = observed();
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v) $display("FAIL b2b_same_button: got %h expected %h", got, exp_v);
    else passed++;
    playerX[0] = 10'd240;
    sb.push_back(mk(HOLD_EN ? 4'b0011 : 4'b0001, 4'b0010, 0, 0, 0, 0, 2'b00, 2'b00));
    tick();
    got = observed();
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v) $display("FAIL b2b_switch: got %h expected %h", got, exp_v);
    else passed++;
    set_idle();
    sb.push_back(mk(HOLD_EN ? 4'b0011 : 4'b0000, HOLD_EN ? 4'b0010 : 4'b0000,
                    0, 0, 0, 0, 2'b00, 2'b00));
    tick();
    got = observed();
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v) $display("FAIL b2b_leave: got %h expected %h", got, exp_v);
    else passed++;
  endtask

  task automatic test_ride_up();
    logic [9:0]  pf_seq [4];
    logic        r_seq  [4];
    logic [1:0]  d_seq  [4];
    pf_seq = '{10'd256, 10'd256, 10'd257, 10'd257};
    r_seq  = '{1'b0, 1'b1, 1'b1, 1'b1};
    d_seq  = '{2'b00, 2'b00, 2'b01, 2'b00};
    set_idle();
    pfX[0] = 10'd100;
    pfY[0] = 10'd256;
    playerX[0] = 10'd110;
    playerY[0] = 10'd224;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pfY[0] = pf_seq[i];
      sb.push_back(mk(4'b0, 4'b0, r_seq[i], 0, 0, 0, d_seq[i], 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL ride_up f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
    end
  endtask

  task automatic test_ride_down_and_off();
    set_idle();
    pfX[1] = 10'd300;
    pfY[1] = 10'd200;
    playerX[0] = 10'd310;
    playerY[0] = 10'd168;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(4'b0, 4'b0, (i == 1), 0, 1, 0, 2'b00, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL ride_land f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
    end
    for (int k = 1; k <= 3; k++) begin
      pfY[1]     = 10'(200 - k);
      playerY[0] = 10'(168 - (k - 1));
      sb.push_back(mk(4'b0, 4'b0, 1, 0, 1, 0, 2'b11, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL ride_down k%0d: got %h expected %h", k, got, exp_v);
      else passed++;
    end
    playerX[0] = 10'd400;
    pfY[1]     = 10'd196;
    playerY[0] = 10'd165;
    sb.push_back(mk(4'b0, 4'b0, 0, 0, 1, 0, 2'b00, 2'b00));
    tick();
    got = observed();
    exp_v = sb.pop_front();
    checks++;
    if (got !== exp_v) $display("FAIL ride_off_edge: got %h expected %h", got, exp_v);
    else passed++;
  endtask

  task automatic test_reset_mid_ride();
    logic [3:0] t_seq [4];
    set_idle();
    pfX[0] = 10'd100;
    pfY[0] = 10'd256;
    playerX[0] = 10'd110;
    playerY[0] = 10'd224;
    playerX[1] = 10'd240;
    playerY[1] = 10'd304;
    do_reset();
    t_seq = '{4'b0001, HOLD_EN ? 4'b0001 : 4'b0000,
              HOLD_EN ? 4'b0001 : 4'b0000, HOLD_EN ? 4'b0001 : 4'b0000};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(4'b0, t_seq[i], (i >= 1), 0, 0, 0, 2'b00, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL pre_reset f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
      playerX[1] = 10'd0;
      playerY[1] = 10'd0;
    end
    RESET = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== 16'h0000) $display("FAIL reset_mid_ride: got %h expected %h", got, 16'h0000);
    else passed++;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(4'b0, 4'b0, (i == 1), 0, 0, 0, 2'b00, 2'b00));
      tick();
      got = observed();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) $display("FAIL post_reset f%0d: got %h expected %h", i, got, exp_v);
      else passed++;
    end
  endtask

  initial begin
    RESET = 1'b0;
    for (int b = 0; b < 4; b++) begin
      buttonX[b] = 10'(15 + 5 * b);
      buttonY[b] = 10'd21;
    end
    set_idle();
    test_reset();
    test_button_hold();
    test_two_players();
    test_back_to_back();
    test_ride_up();
    test_ride_down_and_off();
    test_reset_mid_ride();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
